// File: rtl/tt_capture_sweep.sv
// Truth-table extractor: drives every NUM_IN-bit vector into a network, captures f_in into tt_data.
// Define TT_CAPTURE_WEIGHT_EN to build the popcount accumulator behind tt_weight.
module tt_capture_sweep #(
  parameter int NUM_IN  = 7,
  parameter int LATENCY = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic [NUM_IN-1:0]        x_out,
  input  logic                     f_in,
  output logic                     tt_valid,
  input  logic                     tt_ready,
  output logic [(1<<NUM_IN)-1:0]   tt_data,
  output logic [NUM_IN:0]          tt_weight
);

  localparam int TT_W = 1 << NUM_IN;
  localparam int CW   = NUM_IN + 1;
  localparam logic [CW-1:0] D_LAST = CW'(TT_W - 1);
  localparam logic [CW-1:0] C_FULL = CW'(TT_W);
  localparam logic [2:0]    LAT    = 3'(LATENCY);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, HOLD} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     d_q, d_d;
  logic [CW-1:0]     c_q, c_d;
  logic [2:0]        lat_q, lat_d;
  logic [TT_W-1:0]   tt_data_q, tt_data_d;
  logic              active, accept, cap;

  always_comb begin
    active    = (state_q == SWEEP) || (state_q == DRAIN);
    accept    = (state_q == IDLE) && start;
    // capture runs LATENCY cycles behind the drive side and stops after TT_W samples
    cap       = active && (lat_q == LAT) && (c_q != C_FULL);
    state_d   = state_q;
    d_d       = d_q;
    c_d       = c_q;
    lat_d     = lat_q;
    tt_data_d = tt_data_q;

    if (accept) begin
      d_d       = '0;
      c_d       = '0;
      lat_d     = '0;
      tt_data_d = '0;
    end
    if (active && (lat_q != LAT)) lat_d = lat_q + 3'd1;
    if (cap) begin
      tt_data_d = {f_in, tt_data_q[TT_W-1:1]};
      c_d       = c_q + CW'(1);
    end

    unique case (state_q)
      IDLE:  if (start) state_d = SWEEP;
      SWEEP: begin
        if (d_q == D_LAST) begin
          d_d     = '0;
          state_d = (LATENCY == 0) ? HOLD : DRAIN;
        end else begin
          d_d = d_q + CW'(1);
        end
      end
      DRAIN: if (cap && (c_q == D_LAST)) state_d = HOLD;
      HOLD:  if (tt_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      d_q       <= '0;
      c_q       <= '0;
      lat_q     <= '0;
      tt_data_q <= '0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      c_q       <= c_d;
      lat_q     <= lat_d;
      tt_data_q <= tt_data_d;
    end
  end

`ifdef TT_CAPTURE_WEIGHT_EN
  logic [CW-1:0] weight_q, weight_d;

  always_comb begin
    weight_d = weight_q;
    if (accept) weight_d = '0;
    if (cap)    weight_d = weight_q + CW'(f_in);
  end

  always_ff @(posedge clk) begin
    if (rst) weight_q <= '0;
    else     weight_q <= weight_d;
  end

  assign tt_weight = weight_q;
`else
  assign tt_weight = '0;
`endif

  assign busy     = active;
  assign tt_valid = (state_q == HOLD);
  assign x_out    = (state_q == SWEEP) ? d_q[NUM_IN-1:0] : '0;
  assign tt_data  = tt_data_q;

endmodule

// File: tb/tb_tt_capture_sweep.sv
// Directed bench: two sweepers (LATENCY 0 and 3) run side by side against a behavioural network.
module tb_tt_capture_sweep;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         rdy0, rdy3;
  int           fsel;

  logic         busy0, busy3;
  logic [6:0]   x_out0, x_out3;
  logic         f_in0, f_in3;
  logic         tt_valid0, tt_valid3;
  logic [127:0] tt_data0, tt_data3;
  logic [7:0]   tt_weight0, tt_weight3;
  logic         dly1 = 1'b0, dly2 = 1'b0, dly3 = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

`ifdef TT_CAPTURE_WEIGHT_EN
  localparam bit WEIGHT_ON = 1'b1;
`else
  localparam bit WEIGHT_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic fmodel(input int sel, input logic [6:0] x);
    case (sel)
      0:       fmodel = (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
      1:       fmodel = x[6];
      2:       fmodel = 1'b1;
      3:       fmodel = 1'b0;
      default: fmodel = x[0] ^ x[3];
    endcase
  endfunction

  assign f_in0 = fmodel(fsel, x_out0);

  // three-stage pipelined network for the LATENCY=3 instance
  always @(posedge clk) begin
    dly1 <= fmodel(fsel, x_out3);
    dly2 <= dly1;
    dly3 <= dly2;
  end
  assign f_in3 = dly3;

  tt_capture_sweep #(.NUM_IN(7), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy0), .x_out(x_out0), .f_in(f_in0),
    .tt_valid(tt_valid0), .tt_ready(rdy0), .tt_data(tt_data0), .tt_weight(tt_weight0)
  );

  tt_capture_sweep #(.NUM_IN(7), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .busy(busy3), .x_out(x_out3), .f_in(f_in3),
    .tt_valid(tt_valid3), .tt_ready(rdy3), .tt_data(tt_data3), .tt_weight(tt_weight3)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One start pulse, then wait for both results; cycle 1 is the period after the accept edge.
  task automatic run_sweep(input string name, input int sel, input logic [127:0] exp_tt,
                           input int exp_w, input int restart_at, input bit bp, input bit hs_start);
    int cyc, v0_at, v3_at;
    bit busy_ok;
    int ew;
    ew = WEIGHT_ON ? exp_w : 0;
    fsel = sel;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1; v0_at = 0; v3_at = 0; busy_ok = 1'b1;
    while (1) begin
      if (tt_valid0 && v0_at == 0) v0_at = cyc;
      if (tt_valid3 && v3_at == 0) v3_at = cyc;
      if (cyc <= 131 && !busy3) busy_ok = 1'b0;
      if (cyc == restart_at) begin
        check({name, " x_out at restart"}, x_out0, cyc - 1);
        start = 1'b1;
      end else if (restart_at != 0 && cyc == restart_at + 1) begin
        check({name, " x_out after restart"}, x_out0, cyc - 1);
        start = 1'b0;
      end
      if (v3_at != 0 || cyc >= 300) break;
      @(negedge clk);
      cyc++;
    end
    check({name, " lat0 valid cycle"}, v0_at, 129);
    check({name, " lat3 valid cycle"}, v3_at, 132);
    check({name, " lat3 busy 1..131"}, busy_ok, 1'b1);
    check({name, " lat3 busy in hold"}, busy3, 1'b0);
    check({name, " lat0 tt_data"}, tt_data0, exp_tt);
    check({name, " lat3 tt_data"}, tt_data3, exp_tt);
    check({name, " lat0 weight"}, tt_weight0, ew);
    check({name, " lat3 weight"}, tt_weight3, ew);

    if (bp) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        start = (i == 2);
        check({name, " bp valid"}, tt_valid0, 1'b1);
        check({name, " bp data"}, tt_data0, exp_tt);
      end
      @(negedge clk); start = 1'b0;
      check({name, " bp still hold"}, tt_valid0, 1'b1);
    end

    @(negedge clk);
    start = hs_start; rdy0 = 1'b1; rdy3 = 1'b1;
    @(negedge clk);
    start = 1'b0; rdy0 = 1'b0; rdy3 = 1'b0;
    check({name, " lat0 valid after hs"}, tt_valid0, 1'b0);
    check({name, " lat0 busy after hs"}, busy0, 1'b0);
    check({name, " lat3 valid after hs"}, tt_valid3, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rdy0 = 1'b0; rdy3 = 1'b0; fsel = 0;
    repeat (2) @(negedge clk);
    check("reset busy", busy0, 1'b0);
    check("reset x_out", x_out0, 0);
    check("reset valid", tt_valid0, 1'b0);
    check("reset data", tt_data0, 128'h0);
    check("reset weight", tt_weight0, 0);
    // ready while nothing is valid must not disturb IDLE
    rst = 1'b0; rdy0 = 1'b1;
    @(negedge clk); rdy0 = 1'b0;
    check("idle ready no effect", busy0, 1'b0);

    run_sweep("maj", 0, {16{8'hE8}}, 64, 0, 1'b0, 1'b0);
    run_sweep("x6", 1, {{64{1'b1}}, {64{1'b0}}}, 64, 0, 1'b1, 1'b0);
    run_sweep("ones", 2, {128{1'b1}}, 128, 0, 1'b0, 1'b1);
    run_sweep("zeros", 3, 128'h0, 0, 0, 1'b0, 1'b0);
    run_sweep("xor03", 4, {8{16'h55AA}}, 64, 0, 1'b0, 1'b0);

    // abort mid-sweep at cycle 40
    fsel = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (39) @(negedge clk);
    check("pre-reset x_out", x_out0, 39);
    check("pre-reset busy", busy0, 1'b1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort busy", busy0, 1'b0);
    check("abort x_out", x_out0, 0);
    check("abort valid", tt_valid0, 1'b0);
    check("abort data", tt_data0, 128'h0);
    check("abort lat3 data", tt_data3, 128'h0);
    run_sweep("maj after rst", 0, {16{8'hE8}}, 64, 0, 1'b0, 1'b0);

    run_sweep("maj restart", 0, {16{8'hE8}}, 64, 11, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
